// File: rtl/spi_master_param.sv
// Parametrised SPI master with start/busy/done handshake and per-transfer CPOL/CPHA.
// Optional SPI_LOOPBACK_EN adds loopback_i, which samples the internal mosi instead of miso.
module spi_master_param #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned NUM_CS  = 2,
   parameter int unsigned CS_W    = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic [CS_W-1:0]   cs_sel_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              msb_first_i,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback_i,
`endif
   input  logic              miso_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic [NUM_CS-1:0] cs_n_o
);

   localparam int unsigned HcW = $clog2(CLK_DIV + 1);
   localparam int unsigned EcW = $clog2(2 * DATA_W + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

   state_e              state_q, state_d;
   logic [HcW-1:0]      hc_q, hc_d;
   logic [EcW-1:0]      ec_q, ec_d;
   logic                cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
   logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic                half_end, leading, rx_bit;
   logic [DATA_W-1:0]   shifted;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         hc_q      <= '0;
         ec_q      <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         msb_q     <= 1'b1;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= '1;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         ec_q      <= ec_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         msb_q     <= msb_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         cs_n_q    <= cs_n_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      ec_d      = ec_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      msb_d     = msb_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      cs_n_d    = cs_n_q;
      half_end  = (hc_q == HcW'(CLK_DIV - 1));
      leading   = ~ec_q[0];
      shifted   = msb_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
`ifdef SPI_LOOPBACK_EN
      rx_bit    = loopback_i ? mosi_q : miso_i;
`else
      rx_bit    = miso_i;
`endif

      unique case (state_q)
         StIdle: begin
            // A start coinciding with the done pulse is dropped.
            if (start_i && !done_q) begin
               state_d = StSetup;
               hc_d    = '0;
               ec_d    = '0;
               cpol_d  = cpol_i;
               cpha_d  = cpha_i;
               msb_d   = msb_first_i;
               tx_sh_d = tx_data_i;
               rx_sh_d = '0;
               sclk_d  = cpol_i;
               mosi_d  = msb_first_i ? tx_data_i[DATA_W-1] : tx_data_i[0];
               for (int unsigned i = 0; i < NUM_CS; i++) begin
                  cs_n_d[i] = (32'(cs_sel_i) != i);
               end
            end
         end
         StSetup: begin
            if (half_end) begin
               state_d = StXfer;
               hc_d    = '0;
            end else begin
               hc_d = hc_q + HcW'(1);
            end
         end
         StXfer: begin
            if (!half_end) begin
               hc_d = hc_q + HcW'(1);
            end else begin
               hc_d   = '0;
               sclk_d = ~sclk_q;
               ec_d   = ec_q + EcW'(1);
               if (leading != cpha_q) begin
                  rx_sh_d = msb_q ? {rx_sh_q[DATA_W-2:0], rx_bit} : {rx_bit, rx_sh_q[DATA_W-1:1]};
               end else if (cpha_q ? (ec_q != '0) : (ec_q != EcW'(2 * DATA_W - 1))) begin
                  // Edge 1 in cpha=1 re-presents the bit already driven during setup.
                  tx_sh_d = shifted;
                  mosi_d  = msb_q ? shifted[DATA_W-1] : shifted[0];
               end
               if (ec_q == EcW'(2 * DATA_W - 1)) begin
                  state_d = StHold;
                  ec_d    = '0;
               end
            end
         end
         StHold: begin
            if (half_end) begin
               state_d   = StIdle;
               hc_d      = '0;
               cs_n_d    = '1;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
            end else begin
               hc_d = hc_q + HcW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_o    = (state_q != StIdle);
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;
   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
   assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: SPI slave model, mode/order, boundary and random tests.
// Build with SPI_LOOPBACK_EN defined to also exercise the loopback path.
module tb_spi_master_param;

   localparam int unsigned DW  = 8;
   localparam int unsigned CD  = 2;
   localparam int unsigned NCS = 2;
   localparam int unsigned CSW = 1;
   localparam int          LAT = (2 * DW + 2) * CD + 1;

   logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic           cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1, miso = 1'b0;
   logic [CSW-1:0] cs_sel = '0;
   logic [DW-1:0]  tx_data = '0;
`ifdef SPI_LOOPBACK_EN
   logic           loopback = 1'b0;
`endif
   logic           busy, done, sclk, mosi;
   logic [DW-1:0]  rx_data;
   logic [NCS-1:0] cs_n;

   int n_checks = 0;
   int n_pass   = 0;

   spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(NCS), .CS_W(CSW)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .cpol_i     (cpol),
      .cpha_i     (cpha),
      .cs_sel_i   (cs_sel),
      .tx_data_i  (tx_data),
      .msb_first_i(msb_first),
`ifdef SPI_LOOPBACK_EN
      .loopback_i (loopback),
`endif
      .miso_i     (miso),
      .busy_o     (busy),
      .done_o     (done),
      .rx_data_o  (rx_data),
      .sclk_o     (sclk),
      .mosi_o     (mosi),
      .cs_n_o     (cs_n)
   );

   always #5 clk = ~clk;

   // Slave model: counts SCLK edges while enabled, drives miso and captures mosi.
   logic          slv_en = 1'b0;
   int            slv_edges = 0;
   logic [DW-1:0] slv_word = '0;
   logic          slv_cpha = 1'b0, slv_msb = 1'b1;
   logic          mosi_seen[$];

   function automatic logic bit_at(input logic [DW-1:0] w, input int idx, input logic msb);
      return msb ? w[DW-1-idx] : w[idx];
   endfunction

   always @(sclk) begin
      if (slv_en) begin
         slv_edges = slv_edges + 1;
         #1;
         if (((slv_edges % 2) == 1) != slv_cpha) mosi_seen.push_back(mosi);
         else if (slv_cpha) miso = bit_at(slv_word, (slv_edges - 1) / 2, slv_msb);
         else if (slv_edges / 2 < DW) miso = bit_at(slv_word, slv_edges / 2, slv_msb);
         if (slv_edges == 2 * DW) slv_en = 1'b0;
      end
   end

   function automatic logic [DW-1:0] seen_word(input logic msb);
      logic [DW-1:0] w = '0;
      for (int i = 0; i < DW && i < mosi_seen.size(); i++) w[msb ? DW-1-i : i] = mosi_seen[i];
      return w;
   endfunction

   function automatic logic [NCS-1:0] exp_cs(input logic [CSW-1:0] sel);
      logic [NCS-1:0] m = '1;
      if (32'(sel) < NCS) m[sel] = 1'b0;
      return m;
   endfunction

   // Presents one start pulse and arms the slave; returns in the first cycle after acceptance.
   task automatic launch(input logic p_cpol, input logic p_cpha, input logic [CSW-1:0] p_sel,
                         input logic [DW-1:0] p_tx, input logic p_msb, input logic [DW-1:0] p_slv);
      @(negedge clk);
      cpol = p_cpol; cpha = p_cpha; cs_sel = p_sel; tx_data = p_tx; msb_first = p_msb;
      start = 1'b1;
      slv_word = p_slv; slv_cpha = p_cpha; slv_msb = p_msb; slv_edges = 0;
      mosi_seen.delete();
      miso = p_cpha ? 1'b0 : bit_at(p_slv, 0, p_msb);
      @(negedge clk);
      start = 1'b0;
      slv_en = 1'b1;
   endtask

   task automatic do_xfer(input logic p_cpol, input logic p_cpha, input logic [CSW-1:0] p_sel,
                          input logic [DW-1:0] p_tx, input logic p_msb, input logic [DW-1:0] p_slv,
                          input bit inject, output int lat, output logic [NCS-1:0] cs_mid,
                          output bit busy_ok);
      launch(p_cpol, p_cpha, p_sel, p_tx, p_msb, p_slv);
      lat = -1; busy_ok = 1'b1; cs_mid = '1;
      for (int k = 1; k <= 200; k++) begin
         if (k == CD + 3) cs_mid = cs_n;
         if (inject && k == 10) begin
            start = 1'b1; tx_data = '1; cpol = ~p_cpol; cpha = ~p_cpha;
            msb_first = ~p_msb; cs_sel = ~p_sel;
         end
         if (inject && k == 11) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      slv_en = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({busy, done, rx_data, mosi, cs_n, sclk} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0, 2'b11, 1'b0})
         $display("FAIL reset_state: got busy=%b done=%b rx=%h mosi=%b cs_n=%b sclk=%b, want 0 0 00 0 11 0",
                  busy, done, rx_data, mosi, cs_n, sclk);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (sclk !== 1'b0) $display("FAIL idle_sclk_after_reset: got %b want 0", sclk);
      else n_pass++;
   endtask

   task automatic test_mode0;
      int lat; logic [NCS-1:0] csm; bit bok;
      do_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hD5, 1'b0, lat, csm, bok);
      n_checks++;
      if (rx_data !== 8'hD5) $display("FAIL mode0_rx: got %h want d5", rx_data); else n_pass++;
      n_checks++;
      if (lat !== LAT) $display("FAIL mode0_latency: got %0d want %0d", lat, LAT); else n_pass++;
      n_checks++;
      if (csm !== 2'b10) $display("FAIL mode0_cs_n: got %b want 10", csm); else n_pass++;
      n_checks++;
      if (mosi_seen.size() != DW || seen_word(1'b1) !== 8'h3C)
         $display("FAIL mode0_mosi: got %h (%0d bits) want 3c", seen_word(1'b1), mosi_seen.size());
      else n_pass++;
      n_checks++;
      if (!bok || busy !== 1'b0) $display("FAIL mode0_busy: got ok=%0d busy_at_done=%b want 1 0", bok, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || cs_n !== 2'b11) $display("FAIL mode0_done_pulse: got done=%b cs_n=%b want 0 11", done, cs_n);
      else n_pass++;
   endtask

   task automatic test_mode3;
      int lat; logic [NCS-1:0] csm; bit bok;
      do_xfer(1'b1, 1'b1, 1'b1, 8'hDB, 1'b1, 8'h24, 1'b0, lat, csm, bok);
      n_checks++;
      if (rx_data !== 8'h24) $display("FAIL mode3_rx: got %h want 24", rx_data); else n_pass++;
      n_checks++;
      if (csm !== 2'b01) $display("FAIL mode3_cs_n: got %b want 01", csm); else n_pass++;
      n_checks++;
      if (mosi_seen.size() != DW || seen_word(1'b1) !== 8'hDB)
         $display("FAIL mode3_mosi: got %h want db", seen_word(1'b1));
      else n_pass++;
      n_checks++;
      if (sclk !== 1'b1) $display("FAIL mode3_idle_sclk: got %b want 1", sclk); else n_pass++;
   endtask

   task automatic test_mode1_lsb;
      int lat; logic [NCS-1:0] csm; bit bok;
      do_xfer(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'h80, 1'b0, lat, csm, bok);
      n_checks++;
      if (mosi_seen.size() == 0 || mosi_seen[0] !== 1'b1)
         $display("FAIL mode1_first_mosi: got %0d bits, first=%b want 1", mosi_seen.size(),
                  (mosi_seen.size() == 0) ? 1'bx : mosi_seen[0]);
      else n_pass++;
      n_checks++;
      if (rx_data !== 8'h80) $display("FAIL mode1_rx: got %h want 80", rx_data); else n_pass++;
   endtask

   task automatic test_mid_start;
      int lat; int extra = 0; logic [NCS-1:0] csm; bit bok;
      do_xfer(1'b0, 1'b0, 1'b0, 8'hA6, 1'b1, 8'h5B, 1'b1, lat, csm, bok);
      n_checks++;
      if (!bok || lat !== LAT) $display("FAIL midstart_busy_lat: got ok=%0d lat=%0d want 1 %0d", bok, lat, LAT);
      else n_pass++;
      n_checks++;
      if (seen_word(1'b1) !== 8'hA6 || rx_data !== 8'h5B)
         $display("FAIL midstart_data: got mosi=%h rx=%h want a6 5b", seen_word(1'b1), rx_data);
      else n_pass++;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_checks++;
      if (extra != 0) $display("FAIL midstart_single_done: got %0d extra busy/done cycles want 0", extra);
      else n_pass++;
   endtask

   task automatic test_done_boundary;
      int lat; logic [NCS-1:0] csm; bit bok;
      do_xfer(1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 8'h77, 1'b0, lat, csm, bok);
      start = 1'b1; tx_data = 8'hEE;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL start_on_done: got busy=%b want 0", busy); else n_pass++;
      do_xfer(1'b0, 1'b1, 1'b1, 8'h42, 1'b0, 8'h9E, 1'b0, lat, csm, bok);
      n_checks++;
      if (lat !== LAT || rx_data !== 8'h9E)
         $display("FAIL after_done_xfer: got lat=%0d rx=%h want %0d 9e", lat, rx_data, LAT);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int lat; int dn = 0; int guard = 0; logic [NCS-1:0] csm; bit bok;
      launch(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h99);
      while (slv_edges < 5 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (slv_edges < 5) $display("FAIL reset_mid_wait: got %0d edges want 5", slv_edges); else n_pass++;
      slv_en = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cs_n, sclk, busy, rx_data} !== {2'b11, 1'b0, 1'b0, {DW{1'b0}}})
         $display("FAIL reset_mid_state: got cs_n=%b sclk=%b busy=%b rx=%h want 11 0 0 00",
                  cs_n, sclk, busy, rx_data);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      n_checks++;
      if (dn != 0) $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dn); else n_pass++;
      do_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hD5, 1'b0, lat, csm, bok);
      n_checks++;
      if (rx_data !== 8'hD5 || lat !== LAT || seen_word(1'b1) !== 8'h3C)
         $display("FAIL reset_mid_recover: got rx=%h lat=%0d mosi=%h want d5 %0d 3c",
                  rx_data, lat, seen_word(1'b1), LAT);
      else n_pass++;
   endtask

   task automatic test_random;
      int lat; logic [NCS-1:0] csm; bit bok;
      logic p_cpol, p_cpha, p_msb; logic [CSW-1:0] p_sel; logic [DW-1:0] p_tx, p_slv;
      for (int n = 0; n < 8; n++) begin
         p_cpol = 1'($urandom); p_cpha = 1'($urandom); p_msb = 1'($urandom);
         p_sel = CSW'($urandom_range(NCS - 1)); p_tx = DW'($urandom); p_slv = DW'($urandom);
         do_xfer(p_cpol, p_cpha, p_sel, p_tx, p_msb, p_slv, 1'b0, lat, csm, bok);
         n_checks++;
         if (rx_data !== p_slv || seen_word(p_msb) !== p_tx || mosi_seen.size() != DW ||
             lat !== LAT || csm !== exp_cs(p_sel) || sclk !== p_cpol)
            $display("FAIL random_%0d: got rx=%h mosi=%h lat=%0d cs_n=%b sclk=%b want %h %h %0d %b %b",
                     n, rx_data, seen_word(p_msb), lat, csm, sclk, p_slv, p_tx, LAT, exp_cs(p_sel), p_cpol);
         else n_pass++;
         repeat ($urandom_range(2)) @(negedge clk);
      end
   endtask

`ifdef SPI_LOOPBACK_EN
   task automatic test_loopback;
      int lat; logic [NCS-1:0] csm; bit bok;
      loopback = 1'b1;
      do_xfer(1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, lat, csm, bok);
      loopback = 1'b0;
      n_checks++;
      if (rx_data !== 8'hA5 || csm !== 2'b10)
         $display("FAIL loopback: got rx=%h cs_n=%b want a5 10", rx_data, csm);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_mode1_lsb();
      test_mid_start();
      test_done_boundary();
      test_reset_mid();
      test_random();
`ifdef SPI_LOOPBACK_EN
      test_loopback();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
